// File: rtl/board_tx.sv
// Transmit side of the inter-board link: snapshots the 9x9 board on a send
// request and streams header, 21 packed payload bytes and an XOR checksum.
module board_tx #(
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  send,
    input  logic [8:0][8:0][1:0]  board,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned NCELL = 81;
    localparam int unsigned NPAY  = 21;
    localparam int unsigned IDXW  = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        PAY  = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic [7:0]              csum_q, csum_d;
    logic [NCELL-1:0][1:0]   snap_q, snap_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [NPAY-1:0][7:0]    pay_c;
    logic                    xfer_c;
    logic [1:0]              rst_sync_q;
    logic                    rst_n;

    // Assertion is immediate; release is aligned to clk_in through two flops.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // Four cells per payload byte, cell 4j+m in bits [2m+1:2m].
    always_comb begin
        pay_c = '0;
        for (int j = 0; j < NPAY; j++) begin
            for (int m = 0; m < 4; m++) begin
                if (4 * j + m < NCELL) pay_c[j][2*m +: 2] = snap_q[4*j + m];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        snap_d     = snap_q;
        tx_data_d  = '0;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        xfer_c     = tx_valid_q & tx_ready;

        unique case (state_q)
            IDLE: begin
                if (send) begin
                    for (int r = 0; r < 9; r++) begin
                        for (int c = 0; c < 9; c++) begin
                            snap_d[9*r + c] = (board[r][c] == 2'b11) ? 2'b00 : board[r][c];
                        end
                    end
                    csum_d  = '0;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (xfer_c) begin
                    idx_d   = '0;
                    state_d = PAY;
                end
            end
            PAY: begin
                if (xfer_c) begin
                    csum_d = csum_q ^ pay_c[idx_q];
                    if (idx_q == IDXW'(NPAY - 1)) state_d = CHK;
                    else                          idx_d   = idx_q + IDXW'(1);
                end
            end
            CHK: begin
                if (xfer_c) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Registered outputs track the state being entered.
        unique case (state_d)
            HDR: begin
                tx_data_d  = HEADER;
                tx_valid_d = 1'b1;
                busy_d     = 1'b1;
            end
            PAY: begin
                tx_data_d  = pay_c[idx_d];
                tx_valid_d = 1'b1;
                busy_d     = 1'b1;
            end
            CHK: begin
                tx_data_d  = csum_d;
                tx_valid_d = 1'b1;
                busy_d     = 1'b1;
            end
            DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            csum_q     <= '0;
            snap_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            snap_q     <= snap_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
